ha_accumulator: RTL

Sequential accumulator directly downstream of the hybrid adder family (HA8/HA16/HA32/HA64). It accepts a programmed-length stream of operands over a valid/ready handshake. Each operand is folded into a running sum through one HA<WIDTH> instance. Carry-out is tracked per beat, and the final sum is presented on a held output handshake. This turns the combinational adders into a reusable multi-operand reduction stage.

---
 rtl/ha_acc_pkg.sv | 28 ++
 rtl/HA16.sv | 23 ++
 rtl/HA32.sv | 23 ++
 rtl/HA64.sv | 23 ++
 rtl/HA8.sv | 23 ++
 rtl/ha_accumulator.sv | 122 ++++++++++++
 6 files changed

// File: rtl/ha_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module : ha_acc_pkg
// Brief  : Shared state encoding and WIDTH legality helper for ha_accumulator.
// Rev    : 1.0
// ============================================================================
package ha_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } ha_acc_state_t;

    localparam int c_ha_width_num = 4;
    localparam int c_ha_legal_widths [c_ha_width_num] = '{8, 16, 32, 64};

    function automatic bit ha_width_legal(input int w);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < c_ha_width_num; i++) begin
            if (c_ha_legal_widths[i] == w) ok = 1'b1;
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/HA16.sv
`default_nettype none
// ============================================================================
// Module : HA16
// Brief  : 16-bit hybrid adder, ripple low byte with carry-selected high byte.
// Rev    : 1.0
// ============================================================================
module HA16 (
    output logic [15:0] sum,
    output logic        cout,
    input  logic [15:0] a,
    input  logic [15:0] b
);
    logic [8:0] w_lo;
    logic [8:0] w_hi0;
    logic [8:0] w_hi1;

    assign w_lo  = {1'b0, a[7:0]} + {1'b0, b[7:0]};
    assign w_hi0 = {1'b0, a[15:8]} + {1'b0, b[15:8]};
    assign w_hi1 = w_hi0 + 9'd1;
    assign sum   = {(w_lo[8] ? w_hi1[7:0] : w_hi0[7:0]), w_lo[7:0]};
    assign cout  = w_lo[8] ? w_hi1[8] : w_hi0[8];
endmodule
`default_nettype wire

// File: rtl/HA32.sv
`default_nettype none
// ============================================================================
// Module : HA32
// Brief  : 32-bit hybrid adder, ripple low half with carry-selected high half.
// Rev    : 1.0
// ============================================================================
module HA32 (
    output logic [31:0] sum,
    output logic        cout,
    input  logic [31:0] a,
    input  logic [31:0] b
);
    logic [16:0] w_lo;
    logic [16:0] w_hi0;
    logic [16:0] w_hi1;

    assign w_lo  = {1'b0, a[15:0]} + {1'b0, b[15:0]};
    assign w_hi0 = {1'b0, a[31:16]} + {1'b0, b[31:16]};
    assign w_hi1 = w_hi0 + 17'd1;
    assign sum   = {(w_lo[16] ? w_hi1[15:0] : w_hi0[15:0]), w_lo[15:0]};
    assign cout  = w_lo[16] ? w_hi1[16] : w_hi0[16];
endmodule
`default_nettype wire

// File: rtl/HA64.sv
`default_nettype none
// ============================================================================
// Module : HA64
// Brief  : 64-bit hybrid adder, ripple low half with carry-selected high half.
// Rev    : 1.0
// ============================================================================
module HA64 (
    output logic [63:0] sum,
    output logic        cout,
    input  logic [63:0] a,
    input  logic [63:0] b
);
    logic [32:0] w_lo;
    logic [32:0] w_hi0;
    logic [32:0] w_hi1;

    assign w_lo  = {1'b0, a[31:0]} + {1'b0, b[31:0]};
    assign w_hi0 = {1'b0, a[63:32]} + {1'b0, b[63:32]};
    assign w_hi1 = w_hi0 + 33'd1;
    assign sum   = {(w_lo[32] ? w_hi1[31:0] : w_hi0[31:0]), w_lo[31:0]};
    assign cout  = w_lo[32] ? w_hi1[32] : w_hi0[32];
endmodule
`default_nettype wire

// File: rtl/HA8.sv
`default_nettype none
// ============================================================================
// Module : HA8
// Brief  : 8-bit hybrid adder, ripple low nibble with carry-selected high nibble.
// Rev    : 1.0
// ============================================================================
module HA8 (
    output logic [7:0] sum,
    output logic       cout,
    input  logic [7:0] a,
    input  logic [7:0] b
);
    logic [4:0] w_lo;
    logic [4:0] w_hi0;
    logic [4:0] w_hi1;

    assign w_lo  = {1'b0, a[3:0]} + {1'b0, b[3:0]};
    assign w_hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    assign w_hi1 = w_hi0 + 5'd1;
    assign sum   = {(w_lo[4] ? w_hi1[3:0] : w_hi0[3:0]), w_lo[3:0]};
    assign cout  = w_lo[4] ? w_hi1[4] : w_hi0[4];
endmodule
`default_nettype wire

// File: rtl/ha_accumulator.sv
`default_nettype none
// ============================================================================
// Module : ha_accumulator
// Brief  : Multi-operand reduction over a valid/ready stream using one HA<WIDTH>.
//          Define HA_ACC_SAT_EN for saturating accumulation (default wraps).
// Rev    : 1.0
// ============================================================================
module ha_accumulator
    import ha_acc_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [COUNT_W-1:0] len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_sum,
    output logic               out_carry,
    output logic               busy
);
    ha_acc_state_t      r_state;
    ha_acc_state_t      w_state_nxt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   w_acc_nxt;
    logic               r_carry;
    logic               w_carry_nxt;
    logic [COUNT_W-1:0] r_remaining;
    logic [COUNT_W-1:0] w_remaining_nxt;
    logic [WIDTH-1:0]   w_ha_sum;
    logic               w_ha_cout;

    generate
        if (!ha_width_legal(WIDTH)) begin : g_width_check
            $error("ha_accumulator: WIDTH must be 8, 16, 32 or 64");
        end

        case (WIDTH)
            8: begin : g_ha8
                HA8 u_ha (.sum(w_ha_sum), .cout(w_ha_cout), .a(r_acc), .b(in_data));
            end
            16: begin : g_ha16
                HA16 u_ha (.sum(w_ha_sum), .cout(w_ha_cout), .a(r_acc), .b(in_data));
            end
            32: begin : g_ha32
                HA32 u_ha (.sum(w_ha_sum), .cout(w_ha_cout), .a(r_acc), .b(in_data));
            end
            64: begin : g_ha64
                HA64 u_ha (.sum(w_ha_sum), .cout(w_ha_cout), .a(r_acc), .b(in_data));
            end
            default: begin : g_ha_none
                assign w_ha_sum  = '0;
                assign w_ha_cout = 1'b0;
            end
        endcase
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_carry     <= 1'b0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_carry     <= w_carry_nxt;
            r_remaining <= w_remaining_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_acc_nxt       = r_acc;
        w_carry_nxt     = r_carry;
        w_remaining_nxt = r_remaining;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_acc_nxt   = '0;
                    w_carry_nxt = 1'b0;
                    if (len != '0) begin
                        w_remaining_nxt = len;
                        w_state_nxt     = ACCUM;
                    end else begin
                        w_state_nxt     = DONE;
                    end
                end
            end
            ACCUM: begin
                if (in_valid) begin
`ifdef HA_ACC_SAT_EN
                    // Once at all ones, any nonzero operand overflows again, so saturation sticks.
                    w_acc_nxt = w_ha_cout ? '1 : w_ha_sum;
`else
                    w_acc_nxt = w_ha_sum;
`endif
                    w_carry_nxt     = r_carry | w_ha_cout;
                    w_remaining_nxt = r_remaining - COUNT_W'(1);
                    if (r_remaining == COUNT_W'(1)) w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (r_state == ACCUM);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign out_sum   = (r_state == DONE) ? r_acc : '0;
    assign out_carry = (r_state == DONE) ? r_carry : 1'b0;

endmodule
`default_nettype wire
